// File: rtl/scarv_cop_mem_bridge.sv
// Bridge between the SCARV coprocessor memory port and a request/grant/response bus.
// Optional request timeout with forced error completion is enabled by SCARV_COP_MEM_BRIDGE_TIMEOUT_EN.
module scarv_cop_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    input  logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_rdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,
    output logic        cop_mem_timeout,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_ben,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RSP   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        capture_s;
    logic        timeout_s;
    logic        done_s;
    logic        bus_active_s;
    logic        req_wen_q,   req_wen_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_ben_q,   req_ben_d;

`ifdef SCARV_COP_MEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] cnt_q, cnt_d;

    // A real response arriving on the last counted cycle wins over the timeout.
    always_comb begin
        timeout_s = 1'b0;
        if (((state_q == ST_REQ) || (state_q == ST_RSP)) && (cnt_q == CNT_LAST)) begin
            timeout_s = !((state_q == ST_RSP) && bus_rsp_valid);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Timeout counter next state: cleared on capture, runs only while the transfer is outstanding.
    always_comb begin
        cnt_d = cnt_q;
        if (capture_s) begin
            cnt_d = 16'd0;
        end else if ((state_q == ST_REQ) || (state_q == ST_RSP)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Transfer sequencing; cop_mem_cen only matters where a new request may be taken.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cop_mem_cen) begin
                    capture_s = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_s) begin
                    capture_s = cop_mem_cen;
                    state_d   = cop_mem_cen ? ST_REQ : ST_IDLE;
                end else if (bus_gnt) begin
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RSP: begin
                if (bus_rsp_valid) begin
                    capture_s = cop_mem_cen;
                    state_d   = cop_mem_cen ? ST_REQ : ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RSP;
                end
            end
`ifdef SCARV_COP_MEM_BRIDGE_TIMEOUT_EN
            ST_FLUSH: begin
                if (bus_rsp_valid) begin
                    capture_s = cop_mem_cen;
                    state_d   = cop_mem_cen ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request holding registers next state.
    always_comb begin
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_ben_d   = req_ben_q;
        if (capture_s) begin
            req_wen_d   = cop_mem_wen;
            req_addr_d  = cop_mem_addr;
            req_wdata_d = cop_mem_wdata;
            req_ben_d   = cop_mem_ben;
        end else begin
            req_wen_d   = req_wen_q;
            req_addr_d  = req_addr_q;
            req_wdata_d = req_wdata_q;
            req_ben_d   = req_ben_q;
        end
    end

    // State and request registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_ben_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_ben_q   <= req_ben_d;
        end
    end

    // The bus request is withdrawn in the cycle a timeout abandons it so no grant is lost.
    always_comb begin
        done_s       = (state_q == ST_RSP) && bus_rsp_valid;
        bus_active_s = (state_q == ST_REQ) && !timeout_s;

        bus_req   = bus_active_s;
        bus_wen   = bus_active_s ? req_wen_q   : 1'b0;
        bus_addr  = bus_active_s ? req_addr_q  : 32'd0;
        bus_wdata = bus_active_s ? req_wdata_q : 32'd0;
        bus_ben   = bus_active_s ? req_ben_q   : 4'd0;

        cop_mem_stall   = !(done_s || timeout_s);
        cop_mem_rdata   = done_s ? bus_rsp_rdata : 32'd0;
        cop_mem_error   = done_s ? bus_rsp_error : timeout_s;
        cop_mem_timeout = timeout_s;
    end

endmodule

// File: tb/tb_scarv_cop_mem_bridge.sv
// Randomised transaction-level bench for scarv_cop_mem_bridge; timeout scenarios run when
// SCARV_COP_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_scarv_cop_mem_bridge;

    localparam int TO = 8;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        int          g;      // cycles bus_gnt is withheld in REQ
        int          r;      // cycles bus_rsp_valid is withheld in RSP
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        cop_mem_cen, cop_mem_wen;
    logic [31:0] cop_mem_addr, cop_mem_wdata;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall, cop_mem_error, cop_mem_timeout;
    logic        bus_req, bus_gnt, bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_ben;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_error;

    int n_checks = 0;
    int n_fails  = 0;

    scarv_cop_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben),
        .cop_mem_rdata(cop_mem_rdata), .cop_mem_stall(cop_mem_stall),
        .cop_mem_error(cop_mem_error), .cop_mem_timeout(cop_mem_timeout),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ben(bus_ben),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_error(bus_rsp_error)
    );

    always #5 g_clk = ~g_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.wen   = 1'($urandom_range(0, 1));
        t.addr  = $urandom & 32'hFFFF_FFFC;
        t.wdata = $urandom;
        t.ben   = 4'($urandom_range(0, 15));
        t.g     = $urandom_range(0, 3);
        t.r     = $urandom_range(0, 3);
        t.err   = ($urandom_range(0, 3) == 0);
        t.rdata = $urandom;
        return t;
    endfunction

    function automatic txn_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] ben, input int g, input int r,
                                input logic err, input logic [31:0] rdata);
        txn_t t;
        t.wen = wen; t.addr = addr; t.wdata = wdata; t.ben = ben;
        t.g = g; t.r = r; t.err = err; t.rdata = rdata;
        return t;
    endfunction

    task automatic drive_cop(input logic cen, input txn_t t);
        cop_mem_cen   = cen;
        cop_mem_wen   = t.wen;
        cop_mem_addr  = t.addr;
        cop_mem_wdata = t.wdata;
        cop_mem_ben   = t.ben;
    endtask

    // Processor side noise for cycles where the bridge must not look at cen.
    task automatic drive_junk_cop();
        drive_cop(1'($urandom_range(0, 1)), rand_txn());
    endtask

    task automatic drive_rsp(input logic valid, input logic [31:0] rdata, input logic err);
        bus_rsp_valid = valid;
        bus_rsp_rdata = rdata;
        bus_rsp_error = err;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".stall"},   cop_mem_stall,   32'd1);
        check_eq({tag, ".rdata"},   cop_mem_rdata,   32'd0);
        check_eq({tag, ".error"},   cop_mem_error,   32'd0);
        check_eq({tag, ".timeout"}, cop_mem_timeout, 32'd0);
        check_eq({tag, ".bus_req"}, bus_req,         32'd0);
        check_eq({tag, ".bus_wen"}, bus_wen,         32'd0);
        check_eq({tag, ".bus_addr"},  bus_addr,      32'd0);
        check_eq({tag, ".bus_wdata"}, bus_wdata,     32'd0);
        check_eq({tag, ".bus_ben"},   bus_ben,       32'd0);
    endtask

    task automatic check_bus_req(input string tag, input txn_t t);
        check_eq({tag, ".stall"},     cop_mem_stall, 32'd1);
        check_eq({tag, ".rdata"},     cop_mem_rdata, 32'd0);
        check_eq({tag, ".error"},     cop_mem_error, 32'd0);
        check_eq({tag, ".timeout"},   cop_mem_timeout, 32'd0);
        check_eq({tag, ".bus_req"},   bus_req,   32'd1);
        check_eq({tag, ".bus_wen"},   bus_wen,   32'(t.wen));
        check_eq({tag, ".bus_addr"},  bus_addr,  t.addr);
        check_eq({tag, ".bus_wdata"}, bus_wdata, t.wdata);
        check_eq({tag, ".bus_ben"},   bus_ben,   32'(t.ben));
    endtask

    // Idle (or FLUSH-free) cycle: bridge offers nothing, bus noise must be ignored.
    task automatic idle_cycle(input string tag, input logic cen, input txn_t n);
        drive_cop(cen, n);
        bus_gnt = 1'($urandom_range(0, 1));
        drive_rsp(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        #2;
        check_quiet(tag);
        tick();
    endtask

    // One already-captured transfer: REQ phase, response wait, completion (optionally capturing n).
    task automatic run_txn(input string tag, input txn_t t, input logic nxt_cen, input txn_t n);
        for (int i = 0; i <= t.g; i++) begin
            drive_junk_cop();
            bus_gnt = (i == t.g);
            drive_rsp(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            #2;
            check_bus_req({tag, ".req"}, t);
            tick();
        end
        for (int i = 0; i < t.r; i++) begin
            drive_junk_cop();
            bus_gnt = 1'($urandom_range(0, 1));
            drive_rsp(1'b0, $urandom, 1'($urandom_range(0, 1)));
            #2;
            check_quiet({tag, ".wait"});
            tick();
        end
        drive_cop(nxt_cen, n);
        bus_gnt = 1'($urandom_range(0, 1));
        drive_rsp(1'b1, t.rdata, t.err);
        #2;
        check_eq({tag, ".done.stall"},   cop_mem_stall,   32'd0);
        check_eq({tag, ".done.rdata"},   cop_mem_rdata,   t.rdata);
        check_eq({tag, ".done.error"},   cop_mem_error,   32'(t.err));
        check_eq({tag, ".done.timeout"}, cop_mem_timeout, 32'd0);
        check_eq({tag, ".done.bus_req"}, bus_req,         32'd0);
        tick();
    endtask

    txn_t blank, t, t2, cur, nxt;
    txn_t gat [4];

    initial begin
        blank = mk(1'b0, 32'd0, 32'd0, 4'd0, 0, 0, 1'b0, 32'd0);
        g_reset = 1'b1;
        drive_cop(1'b0, blank);
        bus_gnt = 1'b0;
        drive_rsp(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        g_reset = 1'b0;
        idle_cycle("reset", 1'b0, blank);

        // Single load with minimum latency.
        t = mk(1'b0, 32'h0000_0100, 32'd0, 4'hF, 0, 0, 1'b0, 32'hDEAD_BEEF);
        idle_cycle("load.cap", 1'b1, t);
        run_txn("load", t, 1'b0, blank);
        idle_cycle("load.idle", 1'b0, blank);

        // Store held by a two-cycle grant delay.
        t = mk(1'b1, 32'h0000_0204, 32'h0000_AB00, 4'b0010, 2, 1, 1'b0, 32'd0);
        idle_cycle("store.cap", 1'b1, t);
        run_txn("store", t, 1'b0, blank);

        // Byte gather: cen held, each completion captures the next request.
        for (int i = 0; i < 4; i++) begin
            gat[i] = mk(1'b0, 32'h0000_0300 + 32'(4 * i), 32'd0, 4'(1 << i), i % 2, 1 - (i % 2),
                        1'b0, $urandom);
        end
        idle_cycle("gather.cap", 1'b1, gat[0]);
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("gather%0d", i), gat[i], (i < 3), (i < 3) ? gat[(i + 1) % 4] : blank);
        end

        // Bus error response, then back to IDLE.
        t = mk(1'b0, 32'h0000_0500, 32'd0, 4'hF, 1, 0, 1'b1, 32'h1234_5678);
        idle_cycle("buserr.cap", 1'b1, t);
        run_txn("buserr", t, 1'b0, blank);
        idle_cycle("buserr.idle0", 1'b0, blank);
        idle_cycle("buserr.idle1", 1'b0, blank);

        // Randomised traffic mixing back-to-back chains and idle gaps.
        cur = rand_txn();
        idle_cycle("rnd.cap", 1'b1, cur);
        for (int k = 0; k < 60; k++) begin
            logic chain;
            nxt   = rand_txn();
            chain = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", k), cur, chain, nxt);
            if (!chain) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int j = 0; j < gaps; j++) begin
                    idle_cycle("rnd.gap", 1'b0, rand_txn());
                end
                idle_cycle("rnd.cap", 1'b1, nxt);
            end
            cur = nxt;
        end
        run_txn("rnd.last", cur, 1'b0, blank);

        // Reset while waiting for a response; the late response must be ignored.
        t = mk(1'b0, 32'h0000_0600, 32'd0, 4'hF, 0, 0, 1'b0, 32'd0);
        idle_cycle("rstmid.cap", 1'b1, t);
        drive_cop(1'b0, blank);
        bus_gnt = 1'b1;
        drive_rsp(1'b0, 32'd0, 1'b0);
        #2;
        check_bus_req("rstmid.req", t);
        tick();
        bus_gnt = 1'b0;
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        drive_rsp(1'b1, 32'hCAFE_F00D, 1'b1);
        #2;
        check_quiet("rstmid.late");
        tick();
        t = mk(1'b1, 32'h0000_0704, 32'h5555_AAAA, 4'hC, 1, 1, 1'b0, 32'h0BAD_CAFE);
        idle_cycle("rstmid.recap", 1'b1, t);
        run_txn("rstmid.next", t, 1'b0, blank);

`ifdef SCARV_COP_MEM_BRIDGE_TIMEOUT_EN
        // Granted but never answered: forced error completion on the TO-th cycle after capture.
        t = mk(1'b0, 32'h0000_0800, 32'd0, 4'hF, 0, 0, 1'b0, 32'd0);
        idle_cycle("to.cap", 1'b1, t);
        drive_cop(1'b0, blank);
        bus_gnt = 1'b1;
        drive_rsp(1'b0, 32'd0, 1'b0);
        #2;
        check_bus_req("to.req", t);
        tick();
        bus_gnt = 1'b0;
        for (int i = 2; i < TO; i++) begin
            #2;
            check_quiet("to.wait");
            tick();
        end
        #2;
        check_eq("to.fire.stall",   cop_mem_stall,   32'd0);
        check_eq("to.fire.error",   cop_mem_error,   32'd1);
        check_eq("to.fire.rdata",   cop_mem_rdata,   32'd0);
        check_eq("to.fire.timeout", cop_mem_timeout, 32'd1);
        check_eq("to.fire.bus_req", bus_req,         32'd0);
        tick();
        t2 = mk(1'b1, 32'h0000_0900, 32'h1111_2222, 4'h3, 0, 1, 1'b0, 32'h7777_8888);
        for (int i = 0; i < 2; i++) begin
            drive_cop(1'b1, t2);
            #2;
            check_quiet("to.flush");
            tick();
        end
        drive_rsp(1'b1, 32'hBAD0_BAD0, 1'b1);
        #2;
        check_quiet("to.discard");
        tick();
        run_txn("to.after", t2, 1'b0, blank);

        // Response on the very cycle the timeout would fire: the real response wins.
        t = mk(1'b0, 32'h0000_0A00, 32'd0, 4'hF, 0, TO - 2, 1'b0, 32'h4242_4242);
        idle_cycle("tie.cap", 1'b1, t);
        run_txn("tie", t, 1'b0, blank);

        // Never granted: forced completion from REQ with immediate recapture.
        t  = mk(1'b0, 32'h0000_0B00, 32'd0, 4'hF, 0, 0, 1'b0, 32'd0);
        t2 = mk(1'b0, 32'h0000_0C00, 32'd0, 4'h1, 0, 0, 1'b0, 32'h0000_00C0);
        idle_cycle("toreq.cap", 1'b1, t);
        bus_gnt = 1'b0;
        for (int i = 1; i < TO; i++) begin
            drive_cop(1'b0, blank);
            drive_rsp(1'b0, 32'd0, 1'b0);
            #2;
            check_bus_req("toreq.req", t);
            tick();
        end
        drive_cop(1'b1, t2);
        #2;
        check_eq("toreq.fire.stall",   cop_mem_stall,   32'd0);
        check_eq("toreq.fire.error",   cop_mem_error,   32'd1);
        check_eq("toreq.fire.timeout", cop_mem_timeout, 32'd1);
        check_eq("toreq.fire.bus_req", bus_req,         32'd0);
        tick();
        run_txn("toreq.next", t2, 1'b0, blank);
`endif

        idle_cycle("final.idle", 1'b0, blank);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
